uart_tx: RTL

Serial UART transmitter that frames a parallel byte into start, data and stop bits on a single `tx` line. Bit timing comes from an external 16x-oversampling enable pulse `s_tick`, produced by the team's mod-M baud-rate counter (its `max_tick` output). It pairs with the lab UART receiver on the same baud generator and sits between the user/FIFO side and the board's serial pin.

---
 rtl/uart_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: frames a DBIT-wide word as start, LSB-first data and stop bits,
// with bit timing taken from a 16x-oversampling s_tick enable.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx_busy,
  output logic            tx
);

  localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [S_W-1:0]  s_reg, s_next;
  logic [N_W-1:0]  n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] b_shift;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  function automatic logic bit_end(input logic [S_W-1:0] s);
    return s == S_W'(15);
  endfunction

  function automatic logic stop_end(input logic [S_W-1:0] s);
    return s == S_W'(SB_TICK - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
    end
  end

  assign b_shift = b_reg >> 1;

  // tx is registered, so each branch loads the level the line takes after this edge.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    tx_next    = tx_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_start) begin
          b_next     = din;
          s_next     = '0;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (bit_end(s_reg)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (bit_end(s_reg)) begin
            s_next = '0;
            b_next = b_shift;
            if (n_reg == N_W'(DBIT - 1)) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              n_next  = n_reg + N_W'(1);
              tx_next = b_shift[0];
            end
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (stop_end(s_reg)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + S_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_comb begin
    tx           = tx_reg;
    tx_done_tick = done_reg;
    tx_busy      = (state_reg != IDLE);
  end

endmodule
